// File: rtl/shapool_io_pkg.sv
// Shared types and derived widths for the shapool external-interface controller.
package shapool_io_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StRun,
        StDone,
        StReport
    } state_e;

    // Width of the reported result: winning unit index followed by its nonce.
    function automatic int unsigned result_width(input int unsigned pool_size_log2,
                                                 input int unsigned nonce_width);
        return pool_size_log2 + nonce_width;
    endfunction

endpackage

// File: rtl/shapool_io_if.sv
// Job/result bus between the interface controller (master) and the hashing core (slave).
interface shapool_io_if #(
    parameter int unsigned SHARED_WIDTH   = 352,
    parameter int unsigned DAISY_WIDTH    = 8,
    parameter int unsigned POOL_SIZE_LOG2 = 1,
    parameter int unsigned NONCE_WIDTH    = 32
);

    logic                      core_done;
    logic                      core_success;
    logic [POOL_SIZE_LOG2-1:0] core_idx;
    logic [NONCE_WIDTH-1:0]    core_nonce;
    logic [SHARED_WIDTH-1:0]   job_shared;
    logic [DAISY_WIDTH-1:0]    job_daisy;
    logic                      core_start;
    logic                      core_halt;

    modport master (
        input  core_done,
        input  core_success,
        input  core_idx,
        input  core_nonce,
        output job_shared,
        output job_daisy,
        output core_start,
        output core_halt
    );

    modport slave (
        output core_done,
        output core_success,
        output core_idx,
        output core_nonce,
        input  job_shared,
        input  job_daisy,
        input  core_start,
        input  core_halt
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus single-cycle rise/fall pulses.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser stages followed by the edge-history register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/shapool_io_ctrl.sv
// External-interface controller: loads job data from the serial pins, sequences the
// hashing core, aggregates the done/success chain and shifts the winning result out.
module shapool_io_ctrl
    import shapool_io_pkg::*;
#(
    parameter int unsigned SHARED_WIDTH   = 352,
    parameter int unsigned DAISY_WIDTH    = 8,
    parameter int unsigned POOL_SIZE      = 2,
    parameter int unsigned POOL_SIZE_LOG2 = 1,
    parameter int unsigned NONCE_WIDTH    = 32,
    parameter int unsigned BLINK_LOG2     = 22
) (
    input  logic              hwclk,
    input  logic              reset_in,
    input  logic              data_clk,
    input  logic              data_in,
    output logic              data_out,
    output logic              data_oe,
    input  logic              daisy_sel,
    input  logic              daisy_in,
    output logic              daisy_out,
    input  logic              done_in,
    output logic              done_out,
    input  logic              success_in,
    output logic              success_oe,
    shapool_io_if.master      core,
    output logic              status_led,
    output logic              success_led
);

    localparam int unsigned RESULT_WIDTH = result_width(POOL_SIZE_LOG2, NONCE_WIDTH);
    localparam int unsigned CntW         = $clog2(RESULT_WIDTH + 1);
    localparam logic [POOL_SIZE_LOG2-1:0] IdxMax = POOL_SIZE_LOG2'(POOL_SIZE - 1);

    // Synchronised pin events.
    logic clk_level, clk_rise, clk_fall;
    logic sel_level, sel_rise, sel_fall;
    logic done_level, done_rise, done_fall;
    logic succ_level, succ_rise, succ_fall;

    sync_edge u_sync_data_clk (
        .clk_i   (hwclk),
        .rst_ni  (reset_in),
        .d_i     (data_clk),
        .level_o (clk_level),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    sync_edge u_sync_daisy_sel (
        .clk_i   (hwclk),
        .rst_ni  (reset_in),
        .d_i     (daisy_sel),
        .level_o (sel_level),
        .rise_o  (sel_rise),
        .fall_o  (sel_fall)
    );

    sync_edge u_sync_done_in (
        .clk_i   (hwclk),
        .rst_ni  (reset_in),
        .d_i     (done_in),
        .level_o (done_level),
        .rise_o  (done_rise),
        .fall_o  (done_fall)
    );

    sync_edge u_sync_success_in (
        .clk_i   (hwclk),
        .rst_ni  (reset_in),
        .d_i     (success_in),
        .level_o (succ_level),
        .rise_o  (succ_rise),
        .fall_o  (succ_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{clk_level, clk_fall, done_rise, done_fall, succ_rise, succ_fall};

    state_e                    state_q, state_d;
    logic [SHARED_WIDTH-1:0]   shared_q, shared_d;
    logic [DAISY_WIDTH-1:0]    daisy_q, daisy_d;
    logic [RESULT_WIDTH-1:0]   result_q, result_d;
    logic [CntW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [BLINK_LOG2-1:0]     blink_q, blink_d;
    logic                      daisy_seen_q, daisy_seen_d;
    logic                      start_q, start_d;
    logic                      halt_q, halt_d;
    logic                      win_led_q, win_led_d;
    logic                      done_out_q, done_out_d;
    logic [POOL_SIZE_LOG2-1:0] idx_sat;

    // A unit index outside the pool is saturated so a faulty core cannot name a missing unit.
    assign idx_sat = (core.core_idx > IdxMax) ? IdxMax : core.core_idx;

    // Next-state logic for the job sequencer and all datapath registers.
    always_comb begin
        state_d      = state_q;
        shared_d     = shared_q;
        daisy_d      = daisy_q;
        result_d     = result_q;
        bit_cnt_d    = bit_cnt_q;
        daisy_seen_d = daisy_seen_q;
        start_d      = 1'b0;
        halt_d       = halt_q;
        win_led_d    = win_led_q;
        blink_d      = '0;
        done_out_d   = done_level & (state_q == StDone);

        unique case (state_q)
            StLoad: begin
                if (clk_rise) begin
                    if (sel_level) begin
                        daisy_d      = {daisy_q[DAISY_WIDTH-2:0], daisy_in};
                        daisy_seen_d = 1'b1;
                    end else begin
                        shared_d = {shared_q[SHARED_WIDTH-2:0], data_in};
                    end
                end
                // Releasing daisy_sel after a daisy load launches the job.
                if (sel_fall && daisy_seen_q) begin
                    start_d   = 1'b1;
                    halt_d    = 1'b0;
                    win_led_d = 1'b0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                blink_d = blink_q + BLINK_LOG2'(1);
                if (core.core_success) begin
                    result_d  = {idx_sat, core.core_nonce};
                    bit_cnt_d = '0;
                    halt_d    = 1'b1;
                    win_led_d = 1'b1;
                    state_d   = StReport;
                end else if (succ_level) begin
                    // Another device won; stop and wait for the next job.
                    halt_d       = 1'b1;
                    daisy_seen_d = 1'b0;
                    state_d      = StLoad;
                end else if (core.core_done) begin
                    halt_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (succ_level || sel_rise) begin
                    daisy_seen_d = 1'b0;
                    state_d      = StLoad;
                end
            end
            StReport: begin
                if (clk_rise) begin
                    result_d  = {result_q[RESULT_WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == CntW'(RESULT_WIDTH - 1)) begin
                        daisy_seen_d = 1'b0;
                        state_d      = StLoad;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge hwclk) begin
        if (!reset_in) begin
            state_q      <= StLoad;
            shared_q     <= '0;
            daisy_q      <= '0;
            result_q     <= '0;
            bit_cnt_q    <= '0;
            blink_q      <= '0;
            daisy_seen_q <= 1'b0;
            start_q      <= 1'b0;
            halt_q       <= 1'b0;
            win_led_q    <= 1'b0;
            done_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shared_q     <= shared_d;
            daisy_q      <= daisy_d;
            result_q     <= result_d;
            bit_cnt_q    <= bit_cnt_d;
            blink_q      <= blink_d;
            daisy_seen_q <= daisy_seen_d;
            start_q      <= start_d;
            halt_q       <= halt_d;
            win_led_q    <= win_led_d;
            done_out_q   <= done_out_d;
        end
    end

    // Activity indicator: dark while loading, blinking while hashing, solid once finished.
    always_comb begin
        status_led = 1'b0;
        case (state_q)
            StRun:            status_led = blink_q[BLINK_LOG2-1];
            StDone, StReport: status_led = 1'b1;
            default:          status_led = 1'b0;
        endcase
    end

    assign data_out    = (state_q == StReport) & result_q[RESULT_WIDTH-1];
    assign data_oe     = (state_q == StReport);
    assign success_oe  = (state_q == StReport);
    assign daisy_out   = daisy_q[DAISY_WIDTH-1];
    assign done_out    = done_out_q;
    assign success_led = win_led_q;

    assign core.job_shared = shared_q;
    assign core.job_daisy  = daisy_q;
    assign core.core_start = start_q;
    assign core.core_halt  = halt_q;

endmodule

// File: doc/shapool_io_ctrl.md
# shapool_io_ctrl

Parametrised external-interface controller for a shapool device. It replaces the fixed pin pass-through with a single-clock block that:
- synchronises the off-chip serial bus and loads shared and daisy-chained job data;
- sequences the hashing core through a job;
- aggregates the done/success chain flags;
- shifts the winning result back out.

It sits between the board pins and the hashing core, one instance per device.

## Interface
- SHARED_WIDTH, 352, bits of job data broadcast to every device (midstate + message tail)
- DAISY_WIDTH, 8, bits of per-device data passed along the daisy chain (nonce start)
- POOL_SIZE, 2, number of hash units in the core
- POOL_SIZE_LOG2, 1, width of the winning-unit index
- NONCE_WIDTH, 32, width of the nonce reported by the core
- BLINK_LOG2, 22, status LED blink divider exponent

Ports:
- hwclk  in  1  sole clock
- reset_in  in  1  reset, synchronous, active-low
- data_clk  in  1  external serial clock, asynchronous to hwclk
- data_in  in  1  serial data in
- data_out  out  1  serial result data
- data_oe  out  1  output enable for data_out pin driver
- daisy_sel  in  1  high selects daisy register as shift target
- daisy_in  in  1  daisy serial in
- daisy_out  out  1  daisy serial out (MSB of daisy register)
- done_in  in  1  done flag from previous device
- done_out  out  1  done flag to next device
- success_in  in  1  sampled level of shared success line
- success_oe  out  1  drive shared success line high
- core_done  in  1  core exhausted its nonce range
- core_success  in  1  core found a match (single-cycle pulse)
- core_idx  in  POOL_SIZE_LOG2  winning unit
- core_nonce  in  NONCE_WIDTH  winning nonce
- job_shared  out  SHARED_WIDTH  shared job data to core
- job_daisy  out  DAISY_WIDTH  daisy job data to core
- core_start  out  1  one-cycle start pulse
- core_halt  out  1  level, stops core
- status_led  out  1  activity indicator
- success_led  out  1  local win indicator

## Operation
- data_clk, daisy_sel, done_in and success_in each pass through a 2-FF synchroniser with an edge detector.
- States: LOAD, RUN, DONE, REPORT.

LOAD:
- Each synchronised data_clk rise shifts one bit, MSB first.
  - daisy_sel=0: job_shared <= {job_shared[SHARED_WIDTH-2:0], data_in}.
  - daisy_sel=1: job_daisy <= {job_daisy, daisy_in}.
- Synchronised daisy_sel falling edge with at least one daisy shift since entry: pulse core_start, go to RUN.

RUN:
- data_clk edges are ignored.
- core_success: latch {core_idx, core_nonce} into result register (RESULT_WIDTH = POOL_SIZE_LOG2+NONCE_WIDTH), go to REPORT.
- Else success_in high: assert core_halt, go to LOAD.
- Else core_done: go to DONE.

DONE:
- core_halt=1.
- success_in high or daisy_sel rise: go to LOAD.

REPORT:
- success_oe=1, data_oe=1, core_halt=1.
- data_out = result MSB.
- Each data_clk rise shifts the result left, filling with 0.
- After RESULT_WIDTH rises: go to LOAD.

Chain and indicators:
- done_out = synchronised done_in AND (state==DONE).
- status_led: 0 in LOAD, blink counter bit BLINK_LOG2-1 in RUN, 1 in DONE and REPORT.
- success_led: set on entry to REPORT, cleared on next core_start.

## Timing
- Reset (reset_in=0 at a hwclk edge) forces all of the following, regardless of state:
  - state=LOAD;
  - job_shared, job_daisy, result, bit counter and blink counter = 0;
  - data_out, data_oe, success_oe, done_out, core_start, core_halt, status_led and success_led = 0.
- Reset mid-REPORT drops data_oe and success_oe on the next edge.
- Pin-to-action latency is 3 hwclk cycles (2 synchroniser stages plus edge register). data_clk high and low phases must each be at least 4 hwclk cycles.
- core_start is exactly 1 cycle, in the cycle after the daisy_sel-fall detection.
- In REPORT, data_out for bit k is stable from 1 cycle after the detected rise for bit k-1 (bit 0 from REPORT entry).
- Simultaneous events in RUN are prioritised core_success > success_in > core_done.
- In LOAD, overfilling a register discards older bits; the last SHARED_WIDTH or DAISY_WIDTH bits win.

## Structure
- Package shapool_io_pkg holds the state enum and the RESULT_WIDTH function of the parameters.
- One sub-module, sync_edge: 2-FF synchroniser plus rise/fall pulses, reset to 0. It is instantiated four times.

## Test plan
- Shared load: shift 352 bits of pattern 0xA5... with daisy_sel=0. Required: job_shared equals the pattern and no core_start.
- Daisy start: shift 8 bits 0x3C with daisy_sel=1, then drop daisy_sel. Required: job_daisy=0x3C and core_start a single pulse exactly 3 cycles after the pin fall.
- Local win: in RUN, core_success with core_idx=1 and core_nonce=0xDEADBEEF. Then clock data_clk 33 times. Required: success_oe=1, success_led=1, data_out serialises 0x1DEADBEEF MSB first, and the block returns to LOAD with data_oe=0.
- Remote win: in RUN, success_in high. Required: core_halt=1 and LOAD, with no result shifted. Simultaneous core_success in the same cycle instead yields REPORT.
- Done chain: core_done. Required: done_out follows done_in 3 cycles late and status_led=1.
- Reset mid-REPORT after 10 shifts: reset_in=0 for one cycle. Required: every output 0 and state LOAD.
